// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage; data wins ties.
// Optional fetch anti-starvation is compiled in with `define FETCH_ANTISTARVE_EN.
module mem_port_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_stall,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_stall,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, IF_RD, DM_RD, DM_WR} owner_e;

  owner_e        owner_q, owner_d;
  logic          if_gnt, dm_gnt, force_fetch;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef FETCH_ANTISTARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q, starve_d;

  assign force_fetch = if_req & dm_req & (starve_q == CW'(STARVE_LIMIT));

  // Saturates at the limit; any fetch grant or dropped fetch request restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (dm_req && (starve_q != CW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign dm_stall = dm_req & ~dm_gnt;
`else
  assign force_fetch = 1'b0;
  assign dm_stall    = 1'b0;
`endif

  assign dm_gnt   = dm_req & ~force_fetch;
  assign if_gnt   = if_req & (~dm_req | force_fetch);
  assign if_stall = if_req & ~if_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = IDLE;
    if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      owner_d   = dm_we ? DM_WR : DM_RD;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      owner_d  = IF_RD;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q <= IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Return data passes straight through in its cycle and is held afterwards.
  assign if_rvalid = (owner_q == IF_RD);
  assign dm_rvalid = (owner_q == DM_RD);
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (dm_rvalid) dm_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a queue scoreboard for read returns plus per-cycle grant
// checks. Exercises the anti-starvation path when FETCH_ANTISTARVE_EN is defined.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_stall, if_rvalid, dm_stall, dm_rvalid;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] if_exp_q [$];
  logic [DW-1:0] dm_exp_q [$];
  logic [DW-1:0] if_last, dm_last;
  int            checks   = 0;
  int            failures = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_stall(dm_stall), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected return per cycle while reads are outstanding.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("rst_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
      chk("rst_if_rdata", {24'b0, if_rdata}, 32'd0);
      chk("rst_dm_rdata", {24'b0, dm_rdata}, 32'd0);
      if_last = '0;
      dm_last = '0;
    end else begin
      if (if_exp_q.size() > 0) begin
        chk("if_rvalid", {31'b0, if_rvalid}, 32'd1);
        if_last = if_exp_q.pop_front();
      end else begin
        chk("if_rvalid_idle", {31'b0, if_rvalid}, 32'd0);
      end
      chk("if_rdata", {24'b0, if_rdata}, {24'b0, if_last});
      if (dm_exp_q.size() > 0) begin
        chk("dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
        dm_last = dm_exp_q.pop_front();
      end else begin
        chk("dm_rvalid_idle", {31'b0, dm_rvalid}, 32'd0);
      end
      chk("dm_rdata", {24'b0, dm_rdata}, {24'b0, dm_last});
    end
  end

  // One cycle of stimulus: drive, check the combinational grant at negedge, queue expected returns.
  task automatic step(input string name,
                      input logic ir, input logic [7:0] ia,
                      input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd,
                      input logic e_en, input logic e_we, input logic [7:0] e_addr,
                      input logic [7:0] e_wd, input logic e_ist, input logic e_dst,
                      input logic p_if, input logic [7:0] if_d,
                      input logic p_dm, input logic [7:0] dm_d);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    @(negedge clk);
    $display("txn %s if_req=%0b@%02h dm_req=%0b we=%0b@%02h wd=%02h -> en=%0b we=%0b addr=%02h if_stall=%0b dm_stall=%0b",
             name, ir, ia, dr, dw, da, dd, mem_en, mem_we, mem_addr, if_stall, dm_stall);
    chk({name, "_mem_en"}, {31'b0, mem_en}, {31'b0, e_en});
    chk({name, "_mem_we"}, {31'b0, mem_we}, {31'b0, e_we});
    chk({name, "_mem_addr"}, {24'b0, mem_addr}, {24'b0, e_addr});
    chk({name, "_mem_wdata"}, {24'b0, mem_wdata}, {24'b0, e_wd});
    chk({name, "_if_stall"}, {31'b0, if_stall}, {31'b0, e_ist});
    chk({name, "_dm_stall"}, {31'b0, dm_stall}, {31'b0, e_dst});
    @(posedge clk);
    if (p_if) if_exp_q.push_back(if_d);
    if (p_dm) dm_exp_q.push_back(dm_d);
    #1;
  endtask

  task automatic idle(input string name);
    step(name, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'hC0;
    if_last = '0; dm_last = '0;

    // Reset held with a load pending: mem_* follows the request, returns stay quiet
    rstn = 1'b0;
    if_req = 0; if_addr = 8'h00; dm_req = 1; dm_we = 0; dm_addr = 8'h10; dm_wdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd1);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'h10);
    @(posedge clk); #1;
    dm_req = 0;
    rstn   = 1'b1;
    idle("post_reset");

    // Fetch only
    step("fetch0", 1, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 1, 8'hC0, 0, 8'h00);
    idle("gap1");
    // Conflict: store wins, fetch follows; back-to-back fetch grant
    step("conflict", 1, 8'h07, 1, 1, 8'hC8, 8'h14, 1, 1, 8'hC8, 8'h14, 1, 0, 0, 8'h00, 0, 8'h00);
    step("fetch7", 1, 8'h07, 0, 0, 8'h00, 8'h00, 1, 0, 8'h07, 8'h00, 0, 0, 1, 8'h5D, 0, 8'h00);
    // Store then same-address load, then readback of the earlier store
    step("std_c6", 0, 8'h00, 1, 1, 8'hC6, 8'h27, 1, 1, 8'hC6, 8'h27, 0, 0, 0, 8'h00, 0, 8'h00);
    step("ldd_c6", 0, 8'h00, 1, 0, 8'hC6, 8'h00, 1, 0, 8'hC6, 8'h00, 0, 0, 0, 8'h00, 1, 8'h27);
    step("ldd_c8", 0, 8'h00, 1, 0, 8'hC8, 8'h00, 1, 0, 8'hC8, 8'h00, 0, 0, 0, 8'h00, 1, 8'h14);
    // Fetch grant issued while the previous load returns
    step("fetch1", 1, 8'h01, 0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 0, 0, 1, 8'h5B, 0, 8'h00);
    idle("gap2");
    idle("gap3");

    // Both requests held continuously
    for (int c = 1; c <= 6; c++) begin
`ifdef FETCH_ANTISTARVE_EN
      if (c == 5)
        step("starve_fetch", 1, 8'h07, 1, 0, 8'h10, 8'h00, 1, 0, 8'h07, 8'h00, 0, 1, 1, 8'h5D, 0, 8'h00);
      else
        step("starve_dm", 1, 8'h07, 1, 0, 8'h10, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h00, 1, 8'h4A);
`else
      step("strict_dm", 1, 8'h07, 1, 0, 8'h10, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h00, 1, 8'h4A);
`endif
    end
    idle("gap4");
    idle("gap5");

    // Mid-read reset: the load tag must be discarded
    step("ldd_rst", 0, 8'h00, 1, 0, 8'hC8, 8'h00, 1, 0, 8'hC8, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
    if_req = 0; dm_req = 0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle("after_rst1");
    idle("after_rst2");

    chk("if_queue_drained", if_exp_q.size(), 32'd0);
    chk("dm_queue_drained", dm_exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
